// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: occupancy states
// and default bundle widths.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 96;
  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry for pipe_stage_reg: holds the newer entry while the main
// register is stalled, and owns the registered upstream-ready flop.
// Ports: i_clk, i_reset, i_flush, i_state/i_state_nxt (occupancy),
//        i_up_fire/i_dn_fire (handshakes), i_data/i_ctrl (incoming),
//        o_data/o_ctrl (skid entry), o_up_ready (flop, state != FULL).
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  occ_e              i_state,
  input  occ_e              i_state_nxt,
  input  logic              i_up_fire,
  input  logic              i_dn_fire,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_up_ready
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              rdy_q;
  logic              push;
  logic              pop;

  // New entry parks here only when main is held and not draining.
  assign push = (i_state == BUSY) && i_up_fire
             && !i_dn_fire && !i_flush;
  assign pop  = (i_state == FULL) && i_dn_fire;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (push) begin
      data_q <= i_data;
      ctrl_q <= i_ctrl;
    end else if (i_flush || pop) begin
      ctrl_q <= '0;
    end
  end

  // Ready is looked up from the next state, so it has no path
  // from i_dn_ready this cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) rdy_q <= 1'b1;
    else         rdy_q <= (i_state_nxt != FULL);
  end

  assign o_data     = data_q;
  assign o_ctrl     = ctrl_q;
  assign o_up_ready = rdy_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry
// (PIPE_STAGE_REG_SKID_EN) and a saturating back-pressure counter.
// Ports: i_clk, i_reset (sync, high), i_valid/o_up_ready/i_data/i_ctrl
//        upstream, o_valid/i_dn_ready/o_data/o_ctrl downstream,
//        i_flush, o_occupancy (0..2), o_stall_cnt.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_up_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_dn_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  occ_e              state_q;
  occ_e              state_d;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              vld;
  logic              up_rdy;
  logic              up_fire;
  logic              dn_fire;
  logic              ld_in;

  assign vld     = (state_q != EMPTY) && !i_reset;
  assign up_fire = i_valid && up_rdy;
  assign dn_fire = vld && i_dn_ready;

  // Incoming entry goes straight to main when main is free now.
  assign ld_in = up_fire && !i_flush
              && ((state_q == EMPTY) || dn_fire);

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              rdy_q;
  logic              ld_skid;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_flush),
    .i_state     (state_q),
    .i_state_nxt (state_d),
    .i_up_fire   (up_fire),
    .i_dn_fire   (dn_fire),
    .i_data      (i_data),
    .i_ctrl      (i_ctrl),
    .o_data      (skid_data),
    .o_ctrl      (skid_ctrl),
    .o_up_ready  (rdy_q)
  );

  assign up_rdy  = rdy_q && !i_reset;
  assign ld_skid = (state_q == FULL) && dn_fire && !i_flush;
`else
  assign up_rdy = !i_reset && (!vld || i_dn_ready);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (up_fire) state_d = BUSY;
      end
      BUSY: begin
        if (!up_fire && dn_fire) state_d = EMPTY;
`ifdef PIPE_STAGE_REG_SKID_EN
        else if (up_fire && !dn_fire) state_d = FULL;
`endif
      end
      FULL: begin
        if (dn_fire) state_d = BUSY;
      end
      default: state_d = EMPTY;
    endcase
    if (i_flush) state_d = EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (i_flush) begin
      ctrl_q <= '0;
    end else if (ld_in) begin
      data_q <= i_data;
      ctrl_q <= i_ctrl;
`ifdef PIPE_STAGE_REG_SKID_EN
    end else if (ld_skid) begin
      data_q <= skid_data;
      ctrl_q <= skid_ctrl;
`endif
    end else if (dn_fire) begin
      ctrl_q <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (vld && !i_dn_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_up_ready  = up_rdy;
  assign o_valid     = vld;
  assign o_data      = i_reset ? '0 : data_q;
  assign o_ctrl      = vld ? ctrl_q : '0;
  assign o_occupancy = i_reset ? 2'd0 : state_q;
  assign o_stall_cnt = i_reset ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg against a queue model.
// Build either way: PIPE_STAGE_REG_SKID_EN selects the skid model.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int SAT = 15;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          vin;
  logic          up_rdy;
  logic [DW-1:0] din;
  logic [CW-1:0] cin;
  logic          flush;
  logic          vout;
  logic          dn_rdy;
  logic [DW-1:0] dout;
  logic [CW-1:0] cout;
  logic [1:0]    occ;
  logic [NW-1:0] scnt;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   m_cnt  = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .CNT_W  (NW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_valid     (vin),
    .o_up_ready  (up_rdy),
    .i_data      (din),
    .i_ctrl      (cin),
    .i_flush     (flush),
    .o_valid     (vout),
    .i_dn_ready  (dn_rdy),
    .o_data      (dout),
    .o_ctrl      (cout),
    .o_occupancy (occ),
    .o_stall_cnt (scnt)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  // One clock: drive, check model expectations, advance model.
  task automatic cycle(input logic v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic r,
                       input logic f, input logic rs);
    ent_t e;
    logic mv;
    logic mup;
    vin = v; din = d; cin = c;
    dn_rdy = r; flush = f; rst = rs;
    #1;
    mv = (q.size() != 0) && !rs;
    if (rs) mup = 1'b0;
    else if (CAP == 2) mup = (q.size() < 2);
    else mup = (q.size() == 0) || r;
    chk("up_ready", up_rdy, mup);
    chk("valid", vout, mv);
    chk("ctrl", cout, mv ? q[0].c : '0);
    if (mv) chk("data", dout, q[0].d);
    if (rs) chk("rst_data", dout, '0);
    chk("occupancy", occ, rs ? 0 : q.size());
    chk("stall_cnt", scnt, rs ? 0 : m_cnt);
    if (rs) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (mv && !r && m_cnt < SAT) m_cnt++;
      if (f) begin
        q.delete();
      end else begin
        if (mv && r) void'(q.pop_front());
        if (v && mup) begin
          e.d = d;
          e.c = c;
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] a5;
    a5 = 96'hdead_beef_cafe_f00d_0000_00a5;
    vin = 0; din = '0; cin = '0;
    dn_rdy = 0; flush = 0; rst = 1;

    // reset
    cycle(1, rnd_data(), 8'hff, 1, 0, 1);
    cycle(0, '0, '0, 0, 0, 1);

    // first entry with latency 1, then 100-entry stream
    cycle(1, a5, 8'h81, 1, 0, 0);
    for (int i = 0; i < 100; i++)
      cycle(1, rnd_data(), 8'($urandom), 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);

    // back-pressure window then release
    for (int i = 0; i < 5; i++)
      cycle(1, rnd_data(), 8'($urandom), 0, 0, 0);
    chk("stall_window", scnt, 4);
    for (int i = 0; i < 3; i++)
      cycle(0, '0, '0, 1, 0, 0);

    // fill then flush with a valid input in the same cycle
    cycle(1, rnd_data(), 8'($urandom), 0, 0, 0);
    cycle(1, rnd_data(), 8'($urandom), 0, 0, 0);
    cycle(1, rnd_data(), 8'hc3, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      cycle(0, '0, '0, 1, 0, 0);

    // saturation
    cycle(1, rnd_data(), 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cycle(0, '0, '0, 0, 0, 0);
    chk("stall_sat", scnt, SAT);
    cycle(0, '0, '0, 1, 0, 0);

    // reset in the middle of a stall with counter at 7
    cycle(0, '0, '0, 1, 0, 1);
    cycle(1, rnd_data(), 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 7; i++)
      cycle(0, '0, '0, 0, 0, 0);
    chk("stall_7", scnt, 7);
    cycle(1, rnd_data(), 8'h5a, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), rnd_data(), 8'($urandom),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 63) == 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
